// File: rtl/ram_burst_pkg.sv
// Shared state encoding and read-path constants for the RAM burst initiator.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

  // Cycles from read issue until the RAM output holds the addressed word.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/ram_burst_initiator_if.sv
// Client-side bundle: burst command, write-beat stream and read-beat stream.
interface ram_burst_initiator_if #(
  parameter int width = 8,
  parameter int AW    = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [AW-1:0]    cmd_len;
  logic [width-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [width-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/ram_burst_initiator_rd_fifo.sv
// Read-return FIFO; overflow is prevented upstream by the issue credit check.
module ram_rd_fifo #(
  parameter  int width       = 8,
  parameter  int RFIFO_DEPTH = 4,
  localparam int CW          = $clog2(RFIFO_DEPTH + 1),
  localparam int PW          = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [width-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [width-1:0] mem_q [RFIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop     = pop_i && (count_q != '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ram_burst_initiator.sv
// Burst initiator for a single-port synchronous RAM with 2-cycle read latency.
// Writes pass straight through on handshake; reads are credit-limited into a return FIFO.
module ram_burst_initiator
  import ram_burst_pkg::*;
#(
  parameter  int width       = 8,
  parameter  int depth       = 64,
  parameter  int RFIFO_DEPTH = 4,
  localparam int AW          = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_burst_initiator_if.slave  bus,
  output logic                  busy,
  output logic [width-1:0]      ram_data,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_we,
  input  logic [width-1:0]      ram_q
);
  localparam int CW = $clog2(RFIFO_DEPTH + 1);

  state_e            state_q;
  logic [AW-1:0]     cur_addr_q, beats_left_q, next_addr;
  logic [RD_LAT-1:0] vld_q;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              cmd_hs, wr_hs, issue, pop;

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.wr_ready  = (state_q == WRITE) && !rst;
  assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;
  assign wr_hs         = bus.wr_valid && bus.wr_ready;
  // Reserve a FIFO slot for every read still in the RAM pipeline.
  assign issue = (state_q == READ) && !rst &&
                 ((int'(fifo_count) + $countones(vld_q)) < RFIFO_DEPTH);
  assign busy  = (state_q != IDLE);

  assign next_addr = (cur_addr_q == AW'(depth - 1)) ? '0 : cur_addr_q + 1'b1;
  assign ram_we    = wr_hs;
  assign ram_data  = bus.wr_data;
  assign ram_addr  = ((state_q == WRITE || state_q == READ) && !rst) ? cur_addr_q : '0;

  assign bus.rd_valid = !fifo_empty && !rst;
  assign pop          = bus.rd_valid && bus.rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      vld_q        <= '0;
    end else begin
      vld_q <= {vld_q[RD_LAT-2:0], issue};
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            cur_addr_q   <= bus.cmd_addr;
            beats_left_q <= bus.cmd_len;
            state_q      <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            cur_addr_q   <= next_addr;
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == '0) state_q <= IDLE;
          end
        end
        READ: begin
          if (issue) begin
            cur_addr_q   <= next_addr;
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == '0) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_q == '0 && fifo_empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_rd_fifo #(
    .width      (width),
    .RFIFO_DEPTH(RFIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (vld_q[RD_LAT-1]),
    .push_data_i(ram_q),
    .pop_i      (pop),
    .pop_data_o (bus.rd_data),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );
endmodule

// File: tb/tb_ram_burst_initiator.sv
// Bench for ram_burst_initiator: directed table, corner sequences and random bursts vs a memory model.
module tb_ram_burst_initiator;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy, ram_we;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_addr;

  always #5 clk = ~clk;

  ram_burst_initiator_if #(.width(8), .AW(6)) bus ();

  ram_burst_initiator #(.width(8), .depth(64), .RFIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_we  (ram_we),
    .ram_q   (ram_q)
  );

  // RAM: registered read address, registered output.
  logic [7:0] mem [64];
  logic [5:0] raddr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    raddr_q <= ram_addr;
    ram_q   <= mem[raddr_q];
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] ref_mem [64];
  logic [7:0] wq[$];
  logic [5:0] obs_addr[$];
  logic [7:0] obs_dat[$];
  int         max_cnt;

  typedef struct {
    logic            wr;
    logic [5:0]      addr;
    logic [5:0]      len;
    logic [3:0][7:0] dat;
    logic [3:0][5:0] exp_addr;
    logic [3:0][7:0] exp_dat;
    int              exp_first;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [5:0] addr, input logic [5:0] len);
    bit done = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_handshake", int'(done), 1);
  endtask

  // mode 0: wr_valid always high, 1: pattern 1,0,0,1,1 then high, 2: random gaps
  task automatic write_burst(input logic [5:0] addr, input logic [5:0] len, input int mode);
    int         beat = 0;
    int         nb   = int'(len) + 1;
    logic       v;
    logic [4:0] gap  = 5'b11001;
    logic [5:0] a;
    send_cmd(1'b1, addr, len);
    for (int cyc = 0; cyc < 1000 && beat < nb; cyc++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc < 5) ? gap[cyc] : 1'b1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.wr_valid = v;
      bus.wr_data  = wq[beat];
      @(negedge clk);
      if (cyc == 0) check("wr_busy", int'(busy), 1);
      check("wr_ready", int'(bus.wr_ready), 1);
      check("wr_we", int'(ram_we), int'(v));
      if (v) begin
        a = 6'(int'(addr) + beat);
        check("wr_addr", int'(ram_addr), int'(a));
        check("wr_data", int'(ram_data), int'(wq[beat]));
        obs_addr.push_back(ram_addr);
        ref_mem[a] = wq[beat];
        beat++;
      end
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    check("wr_beats", beat, nb);
    @(negedge clk);
    check("wr_busy_after", int'(busy), 0);
    check("wr_cmd_ready_after", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
  endtask

  // mode 0: rd_ready high, 1: toggling 1/0, 2: random
  task automatic read_burst(input logic [5:0] addr, input logic [5:0] len, input int mode,
                            input int exp_first, input int exp_last);
    logic [7:0] exp_q[$];
    int got = 0, first = -1, last = -1, we_bad = 0;
    int n = int'(len) + 1;
    for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[6'(int'(addr) + k)]);
    send_cmd(1'b0, addr, len);
    for (int i = 0; i < 1000 && got < n; i++) begin
      case (mode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = (i % 2 == 0);
        default: bus.rd_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      if (ram_we) we_bad++;
      if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
      if (bus.rd_valid) begin
        if (first < 0) first = i;
        if (bus.rd_ready) begin
          check("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
          obs_dat.push_back(bus.rd_data);
          got++;
          last = i;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b0;
    check("rd_beats", got, n);
    if (exp_first >= 0) check("rd_first_latency", first, exp_first);
    if (exp_last >= 0) check("rd_last_cycle", last, exp_last);
    check("rd_no_write", we_bad, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("rd_idle_after", int'(busy), 0);
    check("rd_no_extra_beat", int'(bus.rd_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       w;
    logic [5:0] addr, len;
    int         mode, got, bad;

    tbl[0] = '{wr: 1'b1, addr: 6'd5, len: 6'd3, dat: {8'hA3, 8'hA2, 8'hA1, 8'hA0},
               exp_addr: {6'd8, 6'd7, 6'd6, 6'd5}, exp_dat: '0, exp_first: 0};
    tbl[1] = '{wr: 1'b0, addr: 6'd5, len: 6'd3, dat: '0, exp_addr: '0,
               exp_dat: {8'hA3, 8'hA2, 8'hA1, 8'hA0}, exp_first: 3};
    tbl[2] = '{wr: 1'b1, addr: 6'd62, len: 6'd3, dat: {8'h44, 8'h33, 8'h22, 8'h11},
               exp_addr: {6'd1, 6'd0, 6'd63, 6'd62}, exp_dat: '0, exp_first: 0};
    tbl[3] = '{wr: 1'b0, addr: 6'd62, len: 6'd3, dat: '0, exp_addr: '0,
               exp_dat: {8'h44, 8'h33, 8'h22, 8'h11}, exp_first: 3};

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid  = 1'b0; bus.wr_data   = '0;   bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_cmd_ready_low", int'(bus.cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_ready", int'(bus.wr_ready), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    @(posedge clk);
    #1;

    // Full-length write fills every word so later reads are all defined.
    wq.delete();
    for (int k = 0; k < 64; k++) wq.push_back(8'($urandom));
    write_burst(6'd0, 6'd63, 2);

    for (int r = 0; r < 4; r++) begin
      if (tbl[r].wr) begin
        wq.delete();
        obs_addr.delete();
        for (int k = 0; k <= int'(tbl[r].len); k++) wq.push_back(tbl[r].dat[k]);
        write_burst(tbl[r].addr, tbl[r].len, 0);
        for (int k = 0; k < 4; k++)
          check($sformatf("tbl%0d_addr%0d", r, k), int'(obs_addr[k]), int'(tbl[r].exp_addr[k]));
      end else begin
        obs_dat.delete();
        read_burst(tbl[r].addr, tbl[r].len, 0, tbl[r].exp_first, 3 + int'(tbl[r].len));
        for (int k = 0; k < 4; k++)
          check($sformatf("tbl%0d_data%0d", r, k), int'(obs_dat[k]), int'(tbl[r].exp_dat[k]));
      end
    end

    // Write stream with gaps.
    wq.delete();
    obs_addr.delete();
    wq.push_back(8'h5A); wq.push_back(8'h6B); wq.push_back(8'h7C);
    write_burst(6'd20, 6'd2, 1);
    check("gap_addr0", int'(obs_addr[0]), 20);
    check("gap_addr1", int'(obs_addr[1]), 21);
    check("gap_addr2", int'(obs_addr[2]), 22);
    read_burst(6'd20, 6'd2, 0, 3, 5);

    // Backpressured 8-beat read.
    max_cnt = 0;
    read_burst(6'd16, 6'd7, 1, 3, -1);
    check("bp_fifo_bound", int'(max_cnt <= 4), 1);

    // Reset in the middle of an 8-beat read.
    send_cmd(1'b0, 6'd5, 6'd7);
    got = 0;
    for (int i = 0; i < 50 && got < 2; i++) begin
      bus.rd_ready = 1'b1;
      @(negedge clk);
      if (bus.rd_valid) begin
        check("mr_data", int'(bus.rd_data), int'(ref_mem[6'(5 + got)]));
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("mr_beats_before_rst", got, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mr_cmd_ready_in_rst", int'(bus.cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_rd_valid", int'(bus.rd_valid), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_cmd_ready", int'(bus.cmd_ready), 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_valid) bad++;
    end
    check("mr_no_stale_beats", bad, 0);
    @(posedge clk);
    #1;
    bus.rd_ready = 1'b0;
    read_burst(6'd5, 6'd7, 0, 3, 10);

    // Random bursts against the memory model.
    for (int n = 0; n < 24; n++) begin
      w    = 1'($urandom_range(0, 1));
      addr = 6'($urandom_range(0, 63));
      len  = 6'($urandom_range(0, 10));
      mode = $urandom_range(0, 2);
      if (w) begin
        wq.delete();
        for (int k = 0; k <= int'(len); k++) wq.push_back(8'($urandom));
        write_burst(addr, len, mode);
      end else begin
        read_burst(addr, len, mode, 3, (mode == 0) ? 3 + int'(len) : -1);
      end
    end

    // Full-length read starting mid-array, so it wraps.
    read_burst(6'd17, 6'd63, 2, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_burst_initiator.md
Name: ram_burst_initiator

Overview:
- Initiator/controller for the team's single-port synchronous RAM (write port plus registered-address, registered-output read path).
- Accepts burst commands from a client over a valid/ready interface and generates the sequential RAM address/data/write-enable traffic.
- Streams write data in and read data out, with backpressure on both streams.
- Hides the RAM's 2-cycle read latency behind a small credit-managed return FIFO.

Parameters:
- width, 8, RAM data width in bits
- depth, 64, RAM depth in words; AW = $clog2(depth)
- RFIFO_DEPTH, 4, read-return FIFO entries; must be >= 3

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address
- cmd_len  in  AW  beats minus 1 (1..depth beats)
- wr_data  in  width  write beat data
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted when wr_valid and wr_ready are both high
- rd_data  out  width  read beat data
- rd_valid  out  1  read beat available
- rd_ready  in  1  client accepts read beat
- busy  out  1  high whenever state is not IDLE
- ram_data  out  width  to RAM data input
- ram_addr  out  AW  to RAM address
- ram_we  out  1  to RAM write enable
- ram_q  in  width  from RAM output q

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE
  - cmd_ready = 0 while rst is high, 1 in IDLE afterwards
  - wr_ready = 0, rd_valid = 0, ram_we = 0, ram_addr = 0, busy = 0
  - return FIFO empty; read-pipeline valid bits cleared
- Reset mid-burst: remaining beats are abandoned; in-flight reads and buffered data are discarded and never reach rd_valid.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1, ram_we = 0.
  - On cmd handshake: latch cur_addr = cmd_addr and beats_left = cmd_len.
  - Go to WRITE if cmd_write = 1, else READ.
- WRITE:
  - wr_ready = 1.
  - Each wr handshake drives, in the same cycle (combinational pass-through), ram_we = 1, ram_addr = cur_addr, ram_data = wr_data.
  - After each beat: cur_addr increments, beats_left decrements.
  - Beat with beats_left == 0 is the last beat; go to IDLE.
  - wr_valid low: ram_we = 0, no advance.
- READ:
  - Issue a read when inflight + fifo_count < RFIFO_DEPTH.
  - An issue drives ram_we = 0, ram_addr = cur_addr, and pushes 1 into a 2-stage valid shift register.
  - Data issued in cycle t is sampled from ram_q at the end of cycle t+2 and pushed into the FIFO.
  - Last issue (beats_left == 0) goes to DRAIN.
- DRAIN:
  - No issues; ram_we = 0.
  - Go to IDLE once the shift register and the FIFO are both empty.
  - cmd_ready stays low until then, so read beats never interleave with a new burst.
- ram_we is 0 in every cycle that is not a write handshake. This keeps the RAM's read-address register updating.
- Address wrap: cur_addr increments modulo depth; depth-1 is followed by 0.
- Full-length burst (cmd_len = depth-1): exactly depth beats, no overrun.
- Read stream:
  - rd_valid = FIFO not empty; rd_data = FIFO head; pop on rd_valid && rd_ready.
  - Simultaneous push and pop is legal at any fill level.
  - With rd_ready held high, a burst of N beats returns 1 beat/cycle; the first rd_valid appears 3 cycles after the command handshake.
- Write-to-read hazard: a read burst after a write burst to the same address returns the new data. This holds by construction because of the IDLE gap.

Decomposition:
- Package ram_burst_pkg: state enum (IDLE, WRITE, READ, DRAIN) and constant RD_LAT = 2.
- One sub-module, ram_rd_fifo: synchronous FIFO with width and RFIFO_DEPTH parameters, push/pop/count and synchronous reset.

Test Plan:
- Write burst addr=5, len=3, data A0..A3 with wr_valid held high -> ram_we high for 4 consecutive cycles, ram_addr 5,6,7,8; busy falls 1 cycle after the last beat.
- Read back addr=5, len=3 with rd_ready=1 -> rd_data A0,A1,A2,A3 on consecutive cycles, first rd_valid 3 cycles after cmd handshake.
- Wrap: write addr=62, len=3, data 11,22,33,44; then read addr=62, len=3 -> 11 at 62, 22 at 63, 33 at 0, 44 at 1.
- Backpressure: 8-beat read with rd_ready toggling 1/0 -> no beat lost or duplicated; fifo_count never exceeds 4; issue stalls whenever inflight + count = 4.
- Write stream gaps: wr_valid pattern 1,0,0,1,1 over 3 beats -> ram_we follows the handshakes only; addresses remain contiguous.
- rst asserted for 1 cycle mid-read (beat 2 of 8) -> rd_valid = 0 the next cycle, state IDLE, cmd_ready = 1 after rst deasserts; a new command then executes correctly.
